fuel_sequencer: RTL and testbench
=================================

Name: fuel_sequencer

Overview:
- Multi-cycle controller that sequences one shared WIDTH-bit subtractor to evaluate the AoC 2019 Day 1 fuel recurrence: fuel = floor(m/3) - 2.
- The subtractor is built from the team's 1-bit subtraction-adder cells.
- In iterate mode, fuel is re-applied to itself and accumulated until non-positive (Part 2). In single mode, only one step runs (Part 1).
- Sits between the mass input stream and the summing accumulator. Valid/ready on both sides.

Parameters:
- WIDTH, 32, datapath width of mass, fuel and accumulator; also the bit-serial divide step count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset; 0 clears all state immediately.
- in_valid  in  1  mass word offered.
- in_ready  out  1  high only in IDLE.
- in_mass  in  WIDTH  unsigned module mass.
- in_single  in  1  sampled at accept; 1 = one step only (Part 1), 0 = iterate (Part 2).
- out_valid  out  1  result held until taken.
- out_ready  in  1  consumer accepts result.
- out_fuel  out  WIDTH  total fuel for this mass.
- out_ovf  out  1  sticky: accumulator wrapped during this job.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; M, R, Q, F, ACC, count, mode and ovf cleared. Outputs: in_ready=1, out_valid=0, out_fuel=0, out_ovf=0, busy=0.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: M<=in_mass, mode<=in_single, ACC<=0, ovf<=0, R<=0, Q<=0, count<=0; go to DIV.
- DIV: restoring division by 3, one bit per cycle, MSB first, exactly WIDTH cycles.
  - Each cycle: T={R[WIDTH-2:0], M[WIDTH-1-count]}.
  - Shared subtractor computes T-3 as T+~3+1; no-borrow = carry-out.
  - If no borrow: R<=T-3, Q bit=1. Else R<=T, Q bit=0.
  - After count reaches WIDTH-1, go to SUB2.
- SUB2: one cycle; the shared subtractor computes Q-2.
  - If Q<=2, or unsigned borrow: fuel is non-positive; go to DONE, ACC unchanged.
  - Else F<=Q-2; go to ACC.
- ACC: one cycle.
  - {c,ACC}<=ACC+F, wrapping modulo 2^WIDTH; ovf|=c.
  - If mode=1: go to DONE.
  - Else M<=F, R<=0, Q<=0, count<=0; go to DIV.
- DONE:
  - out_valid=1; out_fuel=ACC; out_ovf=ovf; all held stable while out_ready=0.
  - On out_valid & out_ready: go to IDLE.
  - No bypass: the earliest new accept is the edge after the output handshake.
- Latency, counted in edges from the accept edge to out_valid rising:
  - Each positive iteration costs WIDTH+2.
  - The terminating iteration costs WIDTH+1.
  - Single mode with positive fuel: WIDTH+2.
- Boundaries:
  - Mass 0..8 gives fuel 0 after WIDTH+1 edges.
  - Mass at the top of the range (2^WIDTH-1) needs no special casing; R never exceeds 2 and so never overflows.
  - in_valid asserted while busy is ignored; inputs are sampled only at accept.
  - out_ready while not in DONE is ignored.
  - rst asserted mid-job aborts the job; no partial result appears.
  - The subtractor is used by only one state per cycle (DIV or SUB2), so there is never a conflict.

Test Plan:
- Reset, then in_mass=12, single=0, out_ready=1 -> out_valid rises exactly 67 edges after accept; out_fuel=2; out_ovf=0; back in IDLE with in_ready=1 one edge later.
- in_mass=1969, single=0 -> out_fuel=966. in_mass=100756, single=0 -> out_fuel=50346.
- in_mass=1969, single=1 -> out_fuel=654 after 34 edges. in_mass=100756, single=1 -> out_fuel=33583.
- in_mass=8 and in_mass=0 -> out_fuel=0 after 33 edges. in_mass=9 -> out_fuel=1, after 34+33=67 edges.
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid/in_mass -> outputs stable, in_ready=0, nothing accepted; release -> one handshake, then the next mass is accepted.
- Pull rst low mid-DIV on a 100756 job -> immediately out_valid=0, busy=0, in_ready=1; release, submit 14 -> out_fuel=2 with no stale accumulation.

Source files
------------

// File: rtl/fuel_sequencer_if.sv
// fuel_sequencer_if: mass input stream and fuel result stream with valid/ready on both sides.
interface fuel_sequencer_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mass;
  logic             in_single;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_fuel;
  logic             out_ovf;
  modport master (output in_valid, in_mass, in_single, out_ready,
                  input  in_ready, out_valid, out_fuel, out_ovf);
  modport slave  (input  in_valid, in_mass, in_single, out_ready,
                  output in_ready, out_valid, out_fuel, out_ovf);
endinterface

// File: rtl/fuel_sequencer.sv
// fuel_sequencer: multi-cycle fuel = floor(m/3)-2 recurrence on one shared subtractor, single or iterated.
module fuel_sub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module fuel_sequencer #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  fuel_sequencer_if.slave  bus,
  output logic             busy_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, DIV, SUB2, ACC, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d, r_q, r_d, q_q, q_d, f_q, f_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d, idx;
  logic             mode_q, mode_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] t, sa, sb, diff;
  logic [WIDTH:0]   c, sum;
  logic             nb;
  assign idx  = CW'(WIDTH - 1) - cnt_q;
  assign t    = {r_q[WIDTH-2:0], m_q[idx]};
  assign sa   = state_q == SUB2 ? q_q : t;
  assign sb   = state_q == SUB2 ? WIDTH'(2) : WIDTH'(3);
  assign c[0] = 1'b1;
  assign nb   = c[WIDTH];
  assign sum  = {1'b0, acc_q} + {1'b0, f_q};
  // a - b as a + ~b + 1; carry-out high means no borrow
  for (genvar i = 0; i < WIDTH; i++) begin : g_sub
    fuel_sub_cell u_cell (.a_i(sa[i]), .b_i(~sb[i]), .ci_i(c[i]), .s_o(diff[i]), .co_o(c[i+1]));
  end
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    r_d     = r_q;
    q_d     = q_q;
    f_d     = f_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        m_d     = bus.in_mass;
        mode_d  = bus.in_single;
        acc_d   = '0;
        ovf_d   = 1'b0;
        r_d     = '0;
        q_d     = '0;
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        r_d     = nb ? diff : t;
        q_d     = {q_q[WIDTH-2:0], nb};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH - 1) ? SUB2 : DIV;
      end
      SUB2: begin
        f_d     = diff;
        state_d = (!nb || diff == '0) ? DONE : ACC;
      end
      ACC: begin
        acc_d   = sum[WIDTH-1:0];
        ovf_d   = ovf_q | sum[WIDTH];
        state_d = mode_q ? DONE : DIV;
        if (!mode_q) begin
          m_d   = f_q;
          r_d   = '0;
          q_d   = '0;
          cnt_d = '0;
        end
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      f_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      r_q     <= r_d;
      q_q     <= q_d;
      f_q     <= f_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_fuel  = bus.out_valid ? acc_q : '0;
  assign bus.out_ovf   = bus.out_valid & ovf_q;
  assign busy_o        = state_q != IDLE;
endmodule

// File: tb/tb_fuel_sequencer.sv
// tb_fuel_sequencer: vector table, hold/reset corner sequences and random jobs against an arithmetic model.
module tb_fuel_sequencer;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   tests = 0;
  int   fails = 0;
  fuel_sequencer_if #(.WIDTH(W)) bus ();
  fuel_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy_o(busy));
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] mass;
    bit           single;
    logic [W-1:0] fuel;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] m, input bit single,
                       output logic [W-1:0] fuel, output bit ovf, output int lat);
    longint unsigned x, acc;
    x = m;
    acc = 0;
    lat = 0;
    while (1) begin
      x = x / 3;
      if (x <= 2) begin
        lat += W + 1;
        break;
      end
      x -= 2;
      acc += x;
      lat += W + 2;
      if (single) break;
    end
    fuel = acc[W-1:0];
    ovf  = acc >= (64'd1 << W);
  endtask

  task automatic run_job(input logic [W-1:0] mass, input bit single, input bit rdy_early,
                         output logic [W-1:0] fuel, output bit ovf, output int lat,
                         output bit busy_seen, output bit idle_after);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_mass   = mass;
    bus.in_single = single;
    bus.out_ready = rdy_early;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_mass   = $urandom;
    bus.in_single = 1'($urandom);
    busy_seen = busy && !bus.in_ready;
    lat = 0;
    while (!bus.out_valid && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    fuel = bus.out_fuel;
    ovf  = bus.out_ovf;
    if (!rdy_early) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    idle_after = bus.in_ready && !bus.out_valid && !busy;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t         vt[11];
    logic [W-1:0] f, ef;
    bit           o, eo, bs, ia;
    int           l, el;
    vt[0]  = '{32'd12,         1'b0, 32'd2,          67};
    vt[1]  = '{32'd1969,       1'b0, 32'd966,        203};
    vt[2]  = '{32'd100756,     1'b0, 32'd50346,      339};
    vt[3]  = '{32'd1969,       1'b1, 32'd654,        34};
    vt[4]  = '{32'd100756,     1'b1, 32'd33583,      34};
    vt[5]  = '{32'd8,          1'b0, 32'd0,          33};
    vt[6]  = '{32'd0,          1'b0, 32'd0,          33};
    vt[7]  = '{32'd9,          1'b0, 32'd1,          67};
    vt[8]  = '{32'd8,          1'b1, 32'd0,          33};
    vt[9]  = '{32'hFFFF_FFFF,  1'b1, 32'd1431655763, 34};
    vt[10] = '{32'd14,         1'b0, 32'd2,          67};
    bus.in_valid  = 1'b0;
    bus.in_mass   = '0;
    bus.in_single = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_fuel", bus.out_fuel, 0);
    chk("reset out_ovf", bus.out_ovf, 0);
    chk("reset busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      run_job(vt[i].mass, vt[i].single, 1'b0, f, o, l, bs, ia);
      chk($sformatf("vec%0d fuel", i), f, vt[i].fuel);
      chk($sformatf("vec%0d ovf", i), o, 0);
      chk($sformatf("vec%0d latency", i), l, vt[i].lat);
      chk($sformatf("vec%0d busy", i), bs, 1);
      chk($sformatf("vec%0d idle after", i), ia, 1);
    end

    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_mass   = 32'd1969;
    bus.in_single = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (34) @(posedge clk);
    #1;
    chk("hold valid rises", bus.out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.in_valid  = 1'(k & 1);
      bus.in_mass   = $urandom;
      bus.in_single = 1'($urandom);
      @(posedge clk);
      #1;
      chk("hold out_valid", bus.out_valid, 1);
      chk("hold out_fuel", bus.out_fuel, 654);
      chk("hold in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("hold release idle", bus.in_ready, 1);
    run_job(32'd12, 1'b0, 1'b0, f, o, l, bs, ia);
    chk("after hold fuel", f, 2);
    chk("after hold latency", l, 67);

    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_mass   = 32'd100756;
    bus.in_single = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", bus.out_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(32'd14, 1'b0, 1'b0, f, o, l, bs, ia);
    chk("post abort fuel", f, 2);
    chk("post abort latency", l, 67);

    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] m;
      bit           s;
      m = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom);
      model(m, s, ef, eo, el);
      run_job(m, s, 1'($urandom), f, o, l, bs, ia);
      chk($sformatf("rnd%0d m=%0d s=%0d fuel", k, m, s), f, ef);
      chk($sformatf("rnd%0d ovf", k), o, eo);
      chk($sformatf("rnd%0d latency", k), l, el);
      chk($sformatf("rnd%0d idle after", k), ia, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
